// File: rtl/basics_pipe.sv
// basics_pipe
// Parametrised wire / combinational / register teaching block.
//
// Takes an N-bit input vector, passes it straight through, and reduces it to
// a single bit with a mode-selectable function (AND, OR, XOR, majority).
// The reduced bit is then delayed through a DEPTH-stage, enable-gated
// register pipeline.
//
// The pipeline output also drives:
//   - a fill indicator (o_valid),
//   - rising/falling edge pulses,
//   - a saturating count of the rising-edge pulses.
//
// Parameters
//   N      number of single-bit inputs (N >= 1)
//   DEPTH  register stages between o_comb and o_reg (DEPTH >= 1)
//   CW     width of the rising-edge counter (CW >= 1)
//
// Ports
//   clk      system clock, all state updates on its rising edge
//   rst      asynchronous, active-high reset
//   en       pipeline shift enable
//   clr      synchronous clear of the edge counter
//   mode     reduction select: 00 AND, 01 OR, 10 XOR, 11 majority
//   i        N-bit input vector
//   o_wire   combinational copy of i
//   o_comb   combinational reduction of i selected by mode
//   o_reg    last pipeline stage
//   o_valid  pipeline has been filled since reset
//   o_rise   valid-gated rising edge of o_reg
//   o_fall   valid-gated falling edge of o_reg
//   o_count  saturating count of o_rise pulses
module basics_pipe #(
    parameter int N     = 3,
    parameter int DEPTH = 2,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [1:0]    mode,
    input  logic [N-1:0]  i,
    output logic [N-1:0]  o_wire,
    output logic          o_comb,
    output logic          o_reg,
    output logic          o_valid,
    output logic          o_rise,
    output logic          o_fall,
    output logic [CW-1:0] o_count
);

    // Wide enough for a popcount of 0..N and a fill count of 0..DEPTH.
    localparam int PW = $clog2(N + 1);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [PW-1:0]    w_popcount;
    logic             w_majority;
    logic [DEPTH-1:0] r_stage;
    logic [FW-1:0]    r_fill;
    logic             r_reg_d;

    assign o_wire = i;

    // Count the ones in i. Majority is a strict "more than half" test
    // using integer division, so for even N a tie reads as 0.
    always_comb begin
        w_popcount = '0;
        for (int k = 0; k < N; k++) begin
            w_popcount = w_popcount + PW'(i[k]);
        end
        w_majority = (w_popcount > PW'(N / 2));
    end

    // Reduction selected by mode. mode is not registered, so a change
    // shows up here immediately and reaches o_reg DEPTH enabled edges later.
    always_comb begin
        o_comb = 1'b0;
        case (mode)
            2'b00:   o_comb = &i;
            2'b01:   o_comb = |i;
            2'b10:   o_comb = ^i;
            default: o_comb = w_majority;
        endcase
    end

    // Shift register of the reduction. It holds completely while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else if (en) begin
            r_stage[0] <= o_comb;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_reg = r_stage[DEPTH-1];

    // Fill counter. It saturates at DEPTH, so once valid is set it stays set
    // until the next reset, regardless of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill <= '0;
        end else if (en && (r_fill != FW'(DEPTH))) begin
            r_fill <= r_fill + FW'(1);
        end
    end

    assign o_valid = (r_fill == FW'(DEPTH));

    // Edge history sampled every clock, not only enabled ones. That way a
    // pulse lasts exactly one cycle even while the pipeline is stalled.
    // Because it resets to 0, the first valid o_reg=1 counts as a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_d <= 1'b0;
        end else begin
            r_reg_d <= o_reg;
        end
    end

    assign o_rise = o_valid &  o_reg & ~r_reg_d;
    assign o_fall = o_valid & ~o_reg &  r_reg_d;

    // Saturating rise counter. clr wins over a simultaneous rise, and that
    // rise is not counted afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_count <= '0;
        end else if (clr) begin
            o_count <= '0;
        end else if (o_rise && (o_count != CNT_MAX)) begin
            o_count <= o_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_basics_pipe.sv
// Testbench for basics_pipe.
// Two instances share one stimulus stream: the default configuration
// (N=3, DEPTH=2, CW=8) and a CW=2 copy that exercises counter saturation.
// A behavioural model predicts every output and is compared on each falling
// clock edge. Directed phases add hand-computed literal expectations.
module tb_basics_pipe;

    localparam int N     = 3;
    localparam int DEPTH = 2;
    localparam int HSIZE = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [N-1:0] i = '0;
    logic       clkRun = 1'b0;

    logic [N-1:0] o_wire,  s_wire;
    logic         o_comb,  s_comb;
    logic         o_reg,   s_reg;
    logic         o_valid, s_valid;
    logic         o_rise,  s_rise;
    logic         o_fall,  s_fall;
    logic [7:0]   o_count;
    logic [1:0]   s_count;

    int nChecks = 0;
    int nPass   = 0;

    basics_pipe #(.N(N), .DEPTH(DEPTH), .CW(8)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .i(i),
        .o_wire(o_wire), .o_comb(o_comb), .o_reg(o_reg), .o_valid(o_valid),
        .o_rise(o_rise), .o_fall(o_fall), .o_count(o_count)
    );

    basics_pipe #(.N(N), .DEPTH(DEPTH), .CW(2)) dutSat (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .i(i),
        .o_wire(s_wire), .o_comb(s_comb), .o_reg(s_reg), .o_valid(s_valid),
        .o_rise(s_rise), .o_fall(s_fall), .o_count(s_count)
    );

    // Clock starts only when the bench releases it, so reset can be
    // checked first with no clock edge at all.
    initial begin
        wait (clkRun);
        forever #5 clk = ~clk;
    end

    // Behavioural model. It records the reduction value of every enabled
    // edge. o_reg is then the value recorded DEPTH enabled edges ago.
    bit mRed [HSIZE];
    int mEn;
    bit mRegD;
    int mCnt8;
    int mCnt2;

    function automatic bit reduceModel(input logic [N-1:0] v, input logic [1:0] m);
        int ones;
        ones = 0;
        for (int k = 0; k < N; k++) ones += int'(v[k]);
        case (m)
            2'b00:   return ones == N;
            2'b01:   return ones > 0;
            2'b10:   return (ones % 2) == 1;
            default: return ones > (N / 2);
        endcase
    endfunction

    function automatic bit expReg();
        return (mEn >= DEPTH) ? mRed[(mEn - DEPTH) % HSIZE] : 1'b0;
    endfunction

    function automatic bit expValid();
        return mEn >= DEPTH;
    endfunction

    function automatic bit expRise();
        return expValid() && expReg() && !mRegD;
    endfunction

    function automatic bit expFall();
        return expValid() && !expReg() && mRegD;
    endfunction

    // Model state update.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mEn   <= 0;
            mRegD <= 1'b0;
            mCnt8 <= 0;
            mCnt2 <= 0;
        end else begin
            mRegD <= expReg();
            if (clr) begin
                mCnt8 <= 0;
                mCnt2 <= 0;
            end else if (expRise()) begin
                if (mCnt8 < 255) mCnt8 <= mCnt8 + 1;
                if (mCnt2 < 3)   mCnt2 <= mCnt2 + 1;
            end
            if (en) begin
                mRed[mEn % HSIZE] <= reduceModel(i, mode);
                mEn <= mEn + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output of both instances against the model, once per cycle.
    always @(negedge clk) begin
        if (clkRun) begin
            checkOutput("o_wire",  32'(o_wire),  32'(i));
            checkOutput("o_comb",  32'(o_comb),  32'(reduceModel(i, mode)));
            checkOutput("o_reg",   32'(o_reg),   32'(expReg()));
            checkOutput("o_valid", 32'(o_valid), 32'(expValid()));
            checkOutput("o_rise",  32'(o_rise),  32'(expRise()));
            checkOutput("o_fall",  32'(o_fall),  32'(expFall()));
            checkOutput("o_count", 32'(o_count), 32'(mCnt8));
            checkOutput("sat o_reg",   32'(s_reg),   32'(expReg()));
            checkOutput("sat o_count", 32'(s_count), 32'(mCnt2));
        end
    end

    task automatic applyStimulus(input logic e, input logic c, input logic [1:0] m, input logic [N-1:0] v);
        en   = e;
        clr  = c;
        mode = m;
        i    = v;
    endtask

    // Advance one clock and land 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Flush zeros through the pipeline, then push a 1 until it reaches
    // o_reg, then take one more edge so the rise is counted.
    task automatic makeRise();
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b000);
        tick();
        tick();
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b111);
        tick();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nRise;
        int nFall;
        logic [1:0] sweepMode [5];
        logic [N-1:0] sweepIn [5];
        logic sweepExp [5];

        // Reset with the clock stopped.
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkOutput("reset o_reg",   32'(o_reg),   32'd0);
        checkOutput("reset o_valid", 32'(o_valid), 32'd0);
        checkOutput("reset o_rise",  32'(o_rise),  32'd0);
        checkOutput("reset o_fall",  32'(o_fall),  32'd0);
        checkOutput("reset o_count", 32'(o_count), 32'd0);

        // Propagate 111 with AND.
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b111);
        #1;
        checkOutput("and 111 o_comb", 32'(o_comb), 32'd1);
        clkRun = 1'b1;
        tick();
        checkOutput("fill1 o_valid", 32'(o_valid), 32'd0);
        checkOutput("fill1 o_reg",   32'(o_reg),   32'd0);
        tick();
        checkOutput("fill2 o_valid", 32'(o_valid), 32'd1);
        checkOutput("fill2 o_reg",   32'(o_reg),   32'd1);
        checkOutput("fill2 o_rise",  32'(o_rise),  32'd1);
        tick();
        checkOutput("fill3 o_rise",  32'(o_rise),  32'd0);
        checkOutput("fill3 o_count", 32'(o_count), 32'd1);

        // Mode sweep with the pipeline stalled.
        sweepMode = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
        sweepIn   = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b100};
        sweepExp  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, sweepMode[k], sweepIn[k]);
            #1;
            checkOutput("sweep o_comb", 32'(o_comb), 32'(sweepExp[k]));
            checkOutput("sweep o_wire", 32'(o_wire), 32'(sweepIn[k]));
            tick();
        end

        // Enable hold: a 1 sits in stage 0 while o_reg is 0.
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b000);
        tick();
        tick();
        checkOutput("flush o_fall", 32'(o_fall), 32'd1);
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b111);
        tick();
        applyStimulus(1'b0, 1'b0, 2'b00, 3'b111);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("hold o_reg",   32'(o_reg),   32'd0);
            checkOutput("hold o_valid", 32'(o_valid), 32'd1);
            checkOutput("hold o_rise",  32'(o_rise),  32'd0);
            checkOutput("hold o_fall",  32'(o_fall),  32'd0);
        end
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b111);
        tick();
        checkOutput("release o_reg",  32'(o_reg),  32'd1);
        checkOutput("release o_rise", 32'(o_rise), 32'd1);

        // Toggle o_comb every 2 enabled edges.
        nRise = 0;
        nFall = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, 2'b00, ((k / 2) % 2 == 0) ? 3'b000 : 3'b111);
            tick();
            if (o_rise) nRise++;
            if (o_fall) nFall++;
        end
        checkOutput("toggle rises", 32'(nRise), 32'd2);
        checkOutput("toggle falls", 32'(nFall), 32'd2);
        tick();
        checkOutput("toggle o_count",   32'(o_count), 32'd4);
        checkOutput("toggle sat count", 32'(s_count), 32'd3);

        // Fifth rise: the narrow counter stays saturated.
        makeRise();
        checkOutput("sat5 o_count",   32'(o_count), 32'd5);
        checkOutput("sat5 sat count", 32'(s_count), 32'd3);

        // Clear on the same edge as a rise.
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b000);
        tick();
        tick();
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b111);
        tick();
        tick();
        checkOutput("pre-clr o_rise", 32'(o_rise), 32'd1);
        applyStimulus(1'b1, 1'b1, 2'b00, 3'b111);
        tick();
        applyStimulus(1'b1, 1'b0, 2'b00, 3'b111);
        tick();
        checkOutput("clr o_count",   32'(o_count), 32'd0);
        checkOutput("clr sat count", 32'(s_count), 32'd0);

        // Reset in the middle of a run.
        makeRise();
        makeRise();
        checkOutput("pre-rst o_count", 32'(o_count), 32'd2);
        checkOutput("pre-rst o_reg",   32'(o_reg),   32'd1);
        checkOutput("pre-rst o_valid", 32'(o_valid), 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst o_reg",   32'(o_reg),   32'd0);
        checkOutput("midrst o_valid", 32'(o_valid), 32'd0);
        checkOutput("midrst o_count", 32'(o_count), 32'd0);
        checkOutput("midrst o_rise",  32'(o_rise),  32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("refill1 o_valid", 32'(o_valid), 32'd0);
        tick();
        checkOutput("refill2 o_valid", 32'(o_valid), 32'd1);
        checkOutput("refill2 o_rise",  32'(o_rise),  32'd1);
        tick();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
